// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and load/store; one access in flight, at least one idle cycle between grants.
// Latency: grant registered one edge after request, result captured on the ack edge; stallreq_o holds the pipeline until both requests are done.
module mem_arbiter #(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_ce_i,
    input  logic [31:0] inst_addr_i,
    output logic [31:0] inst_data_o,

    input  logic        data_ce_i,
    input  logic        data_we_i,
    input  logic [31:0] data_addr_i,
    input  logic [3:0]  data_sel_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,

    output logic        stallreq_o,

    output logic        mem_ce_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_sel_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DATA_ACC = 2'd1,
        INST_ACC = 2'd2
    } state_t;

    state_t      state_q;
    logic        inst_done_q;
    logic        data_done_q;
    logic        mem_ce_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_sel_q;
    logic [31:0] inst_data_q;
    logic [31:0] data_rdata_q;

    logic pend_d;
    logic pend_i;
    logic grant_d;
    logic grant_i;

    assign pend_d     = data_ce_i & ~data_done_q;
    assign pend_i     = inst_ce_i & ~inst_done_q;
    assign stallreq_o = pend_d | pend_i | (state_q != IDLE);

    // Priority only matters when both ports are pending in the same idle cycle.
    assign grant_d = DATA_FIRST ? pend_d : (pend_d & ~pend_i);
    assign grant_i = DATA_FIRST ? (pend_i & ~pend_d) : pend_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            inst_done_q  <= 1'b0;
            data_done_q  <= 1'b0;
            mem_ce_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            mem_sel_q    <= 4'd0;
            inst_data_q  <= 32'd0;
            data_rdata_q <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!stallreq_o) begin
                        inst_done_q <= 1'b0;
                        data_done_q <= 1'b0;
                    end
                    if (grant_d) begin
                        state_q     <= DATA_ACC;
                        mem_ce_q    <= 1'b1;
                        mem_we_q    <= data_we_i;
                        mem_addr_q  <= data_addr_i;
                        mem_sel_q   <= data_sel_i;
                        mem_wdata_q <= data_wdata_i;
                    end else if (grant_i) begin
                        state_q     <= INST_ACC;
                        mem_ce_q    <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= inst_addr_i;
                        mem_sel_q   <= 4'b1111;
                        mem_wdata_q <= 32'd0;
                    end
                end
                DATA_ACC: begin
                    if (mem_ack_i) begin
                        state_q     <= IDLE;
                        mem_ce_q    <= 1'b0;
                        data_done_q <= data_ce_i;
                        if (!mem_we_q) begin
                            data_rdata_q <= mem_rdata_i;
                        end
                    end
                end
                INST_ACC: begin
                    if (mem_ack_i) begin
                        state_q     <= IDLE;
                        mem_ce_q    <= 1'b0;
                        inst_done_q <= inst_ce_i;
                        inst_data_q <= mem_rdata_i;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    mem_ce_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_ce_o     = mem_ce_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign mem_sel_o    = mem_sel_q;
    assign inst_data_o  = inst_data_q;
    assign data_rdata_o = data_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 has data priority, instance 1 instruction priority, each with its own request stream.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        inst_ce    [2];
    logic [31:0] inst_addr  [2];
    logic        data_ce    [2];
    logic        data_we    [2];
    logic [31:0] data_addr  [2];
    logic [3:0]  data_sel   [2];
    logic [31:0] data_wdata [2];
    logic        ack        [2];
    logic [31:0] rdata      [2];

    logic [31:0] inst_data  [2];
    logic [31:0] data_rdata [2];
    logic        stall      [2];
    logic        mce        [2];
    logic        mwe        [2];
    logic [31:0] maddr      [2];
    logic [31:0] mwdata     [2];
    logic [3:0]  msel       [2];

    genvar g;
    for (g = 0; g < 2; g++) begin : g_dut
        mem_arbiter #(.DATA_FIRST(g == 0)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .inst_ce_i   (inst_ce[g]),
            .inst_addr_i (inst_addr[g]),
            .inst_data_o (inst_data[g]),
            .data_ce_i   (data_ce[g]),
            .data_we_i   (data_we[g]),
            .data_addr_i (data_addr[g]),
            .data_sel_i  (data_sel[g]),
            .data_wdata_i(data_wdata[g]),
            .data_rdata_o(data_rdata[g]),
            .stallreq_o  (stall[g]),
            .mem_ce_o    (mce[g]),
            .mem_we_o    (mwe[g]),
            .mem_addr_o  (maddr[g]),
            .mem_wdata_o (mwdata[g]),
            .mem_sel_o   (msel[g]),
            .mem_rdata_i (rdata[g]),
            .mem_ack_i   (ack[g])
        );
    end

    // Memory contents: a few fixed words, everything else derived from the address.
    function automatic logic [31:0] memval(input logic [31:0] a);
        case (a)
            32'h0000_0010: return 32'h3401_1100;
            32'h0000_0014: return 32'h8C02_0100;
            32'h0000_0100: return 32'hDEAD_BEEF;
            default:       return {a[15:0], ~a[15:0]};
        endcase
    endfunction

    always_comb begin
        for (int k = 0; k < 2; k++) rdata[k] = memval(maddr[k]);
    end

    // Reference: who owns the memory port (0 none, 1 data, 2 fetch), what was issued, what was returned.
    typedef struct packed {
        logic [1:0]  owner;
        logic        dd;
        logic        id;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] idat;
        logic [31:0] ddat;
    } mdl_t;

    mdl_t mdl [2];

    function automatic logic exp_stall(input int k);
        return (data_ce[k] & ~mdl[k].dd) | (inst_ce[k] & ~mdl[k].id) | (mdl[k].owner != 2'd0);
    endfunction

    function automatic mdl_t step(input mdl_t m, input int k);
        mdl_t n;
        logic pd;
        logic pi;
        n  = m;
        pd = data_ce[k] & ~m.dd;
        pi = inst_ce[k] & ~m.id;
        if (m.owner == 2'd0) begin
            if (!pd && !pi) begin
                n.dd = 1'b0;
                n.id = 1'b0;
            end else if (pd && (k == 0 || !pi)) begin
                n.owner = 2'd1;
                n.addr  = data_addr[k];
                n.sel   = data_sel[k];
                n.we    = data_we[k];
                n.wdata = data_wdata[k];
            end else begin
                n.owner = 2'd2;
                n.addr  = inst_addr[k];
                n.sel   = 4'hF;
                n.we    = 1'b0;
                n.wdata = 32'd0;
            end
        end else if (ack[k]) begin
            if (m.owner == 2'd1) begin
                n.dd = data_ce[k];
                if (!m.we) n.ddat = rdata[k];
            end else begin
                n.id   = inst_ce[k];
                n.idat = rdata[k];
            end
            n.owner = 2'd0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) mdl[k] <= '0;
        end else begin
            for (int k = 0; k < 2; k++) mdl[k] <= step(mdl[k], k);
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %h expected %h", nm, k, act, exp);
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk("stallreq", k, 32'(stall[k]), 32'(exp_stall(k)));
            chk("mem_ce", k, 32'(mce[k]), 32'(mdl[k].owner != 2'd0));
            chk("inst_data", k, inst_data[k], mdl[k].idat);
            chk("data_rdata", k, data_rdata[k], mdl[k].ddat);
            if (mdl[k].owner != 2'd0) begin
                chk("mem_addr", k, maddr[k], mdl[k].addr);
                chk("mem_sel", k, 32'(msel[k]), 32'(mdl[k].sel));
                chk("mem_we", k, 32'(mwe[k]), 32'(mdl[k].we));
                chk("mem_wdata", k, mwdata[k], mdl[k].wdata);
            end
        end
    end

    task automatic clr_all();
        for (int k = 0; k < 2; k++) begin
            inst_ce[k]    = 1'b0;
            inst_addr[k]  = 32'd0;
            data_ce[k]    = 1'b0;
            data_we[k]    = 1'b0;
            data_addr[k]  = 32'd0;
            data_sel[k]   = 4'd0;
            data_wdata[k] = 32'd0;
            ack[k]        = 1'b0;
        end
    endtask

    task automatic set_fetch(input logic [31:0] a);
        for (int k = 0; k < 2; k++) begin
            inst_ce[k]   = 1'b1;
            inst_addr[k] = a;
        end
    endtask

    task automatic set_data(input logic we, input logic [31:0] a, input logic [3:0] s, input logic [31:0] wd);
        for (int k = 0; k < 2; k++) begin
            data_ce[k]    = 1'b1;
            data_we[k]    = we;
            data_addr[k]  = a;
            data_sel[k]   = s;
            data_wdata[k] = wd;
        end
    endtask

    task automatic set_ack(input logic v);
        for (int k = 0; k < 2; k++) ack[k] = v;
    endtask

    // Counts stall cycles per instance and notes the first granted address; drops requests once released.
    task automatic run_until_free(output int c0, output int c1, output logic [31:0] fa0, output logic [31:0] fa1);
        int          c    [2];
        logic        done [2];
        logic        seen [2];
        logic [31:0] fa   [2];
        for (int k = 0; k < 2; k++) begin
            c[k] = 0; done[k] = 1'b0; seen[k] = 1'b0; fa[k] = 32'hFFFF_FFFF;
        end
        for (int t = 0; t < 100 && !(done[0] && done[1]); t++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!done[k]) begin
                    if (mce[k] && !seen[k]) begin
                        seen[k] = 1'b1;
                        fa[k]   = maddr[k];
                    end
                    if (stall[k]) c[k]++;
                    else done[k] = 1'b1;
                end
            end
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                if (done[k]) begin
                    inst_ce[k] = 1'b0;
                    data_ce[k] = 1'b0;
                end
            end
        end
        chk("release_within_budget", 0, {30'd0, done[0], done[1]}, 32'd3);
        c0 = c[0]; c1 = c[1]; fa0 = fa[0]; fa1 = fa[1];
    endtask

    task automatic new_req(input int k);
        data_ce[k]    = ($urandom_range(0, 2) != 0);
        data_we[k]    = $urandom_range(0, 1) == 1;
        data_addr[k]  = $urandom & 32'hFFFF_FFFC;
        data_sel[k]   = 4'($urandom_range(0, 15));
        data_wdata[k] = $urandom;
        inst_ce[k]    = ($urandom_range(0, 3) != 0);
        inst_addr[k]  = $urandom & 32'hFFFF_FFFC;
    endtask

    int          c0, c1;
    logic [31:0] fa0, fa1;
    logic        free [2];

    initial begin
        rst = 1'b0;
        clr_all();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_stall", k, 32'(stall[k]), 32'd0);
            chk("reset_mem_ce", k, 32'(mce[k]), 32'd0);
            chk("reset_mem_addr", k, maddr[k], 32'd0);
            chk("reset_mem_sel", k, 32'(msel[k]), 32'd0);
            chk("reset_inst_data", k, inst_data[k], 32'd0);
            chk("reset_data_rdata", k, data_rdata[k], 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b1;

        // Fetch only, one-cycle ack.
        set_fetch(32'h10);
        set_ack(1'b1);
        run_until_free(c0, c1, fa0, fa1);
        chk("fetch_stall_cycles", 0, c0, 32'd2);
        chk("fetch_addr", 0, fa0, 32'h10);
        chk("fetch_inst_data", 0, inst_data[0], 32'h3401_1100);

        // Load and fetch together.
        set_data(1'b0, 32'h100, 4'hF, 32'd0);
        set_fetch(32'h14);
        run_until_free(c0, c1, fa0, fa1);
        chk("both_stall_cycles", 0, c0, 32'd4);
        chk("both_first_grant", 0, fa0, 32'h100);
        chk("both_data_rdata", 0, data_rdata[0], 32'hDEAD_BEEF);
        chk("both_inst_data", 0, inst_data[0], 32'h8C02_0100);
        chk("both_stall_cycles", 1, c1, 32'd4);
        chk("inst_first_grant", 1, fa1, 32'h14);

        // Store with a three-cycle ack.
        set_ack(1'b0);
        set_data(1'b1, 32'h200, 4'b0011, 32'h0000_ABCD);
        @(negedge clk);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("store_ce", 0, 32'(mce[0]), 32'd1);
            chk("store_we", 0, 32'(mwe[0]), 32'd1);
            chk("store_addr", 0, maddr[0], 32'h200);
            chk("store_sel", 0, 32'(msel[0]), 32'h3);
            chk("store_wdata", 0, mwdata[0], 32'h0000_ABCD);
            if (i == 2) set_ack(1'b1);
            @(posedge clk); #1;
        end
        run_until_free(c0, c1, fa0, fa1);
        for (int k = 0; k < 2; k++) chk("store_keeps_rdata", k, data_rdata[k], 32'hDEAD_BEEF);

        // Reset in the second cycle of a load.
        set_ack(1'b0);
        set_data(1'b0, 32'h300, 4'hF, 32'd0);
        repeat (2) begin
            @(negedge clk);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_mid_mem_ce", k, 32'(mce[k]), 32'd0);
            chk("rst_mid_mem_we", k, 32'(mwe[k]), 32'd0);
            chk("rst_mid_mem_addr", k, maddr[k], 32'd0);
            chk("rst_mid_mem_sel", k, 32'(msel[k]), 32'd0);
            chk("rst_mid_mem_wdata", k, mwdata[k], 32'd0);
            chk("rst_mid_inst_data", k, inst_data[k], 32'd0);
            chk("rst_mid_data_rdata", k, data_rdata[k], 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("reissue_stall", 0, 32'(stall[0]), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("reissue_ce", 0, 32'(mce[0]), 32'd1);
        chk("reissue_addr", 0, maddr[0], 32'h300);
        set_ack(1'b1);
        @(posedge clk); #1;
        run_until_free(c0, c1, fa0, fa1);
        chk("reissue_rdata", 0, data_rdata[0], 32'h0300_FCFF);

        // Stray ack with nothing requested.
        clr_all();
        set_ack(1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("stray_stall", 0, 32'(stall[0]), 32'd0);
            chk("stray_ce", 0, 32'(mce[0]), 32'd0);
            chk("stray_inst_data", 0, inst_data[0], 32'd0);
            chk("stray_data_rdata", 0, data_rdata[0], 32'h0300_FCFF);
            @(posedge clk); #1;
        end

        // Randomized traffic; each instance gets a new request only after it releases the pipeline.
        for (int k = 0; k < 2; k++) free[k] = 1'b1;
        repeat (3000) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) free[k] = !exp_stall(k);
            @(posedge clk); #1;
            if (!rst) rst = 1'b1;
            else if ($urandom_range(0, 299) == 0) rst = 1'b0;
            for (int k = 0; k < 2; k++) begin
                if (free[k]) new_req(k);
                ack[k] = ($urandom_range(0, 9) < 4);
            end
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
